// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-organised memory port for byte, halfword and word
// accesses, doing read-modify-write for sub-word stores and extension for loads.
module load_store_unit #(
  parameter int addresswidth = 30,
  parameter int width        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [31:0]             req_addr,
  input  logic [width-1:0]        req_wdata,
  output logic                    resp_valid,
  output logic [width-1:0]        resp_rdata,
  output logic                    resp_error,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_writeEnable,
  output logic [width-1:0]        mem_dataIn,
  input  logic [width-1:0]        mem_dataOut
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [width-1:0]  data_q, data_d;
  logic [width-1:0]  rdata_q, rdata_d;
  logic              error_q, error_d;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lo[0];
      2'b10:   r = (lo != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of word with the low bits of wdata; word stores pass wdata.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          data_d   = req_wdata;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            rdata_d = 32'h0000_0000;
            error_d = 1'b1;
            state_d = S_RESP;
          end else if (req_write && (req_size == 2'b10)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // Sub-word stores fold the fetched word into the write buffer here.
        if (write_q) begin
          data_d  = merge_lane(mem_dataOut, data_q, addr_q[1:0], size_q);
          state_d = S_WRITE;
        end else begin
          rdata_d = extract_lane(mem_dataOut, addr_q[1:0], size_q, signed_q);
          error_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        rdata_d = 32'h0000_0000;
        error_d = 1'b0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0000_0000;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      data_q   <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign resp_valid      = (state_q == S_RESP);
  assign mem_writeEnable = (state_q == S_WRITE);
  assign resp_rdata      = rdata_q;
  assign resp_error      = error_q;
  assign mem_address     = addr_q[addresswidth+1:2];
  assign mem_dataIn      = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests
// compared against an arithmetic model of memory and response behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [29:0] mem_address;
  logic        mem_writeEnable;
  logic [31:0] mem_dataIn, mem_dataOut;

  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16];
  int          we_total = 0;
  logic [29:0] we_addr;
  logic [31:0] we_data;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.addresswidth(30), .width(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  assign mem_dataOut = mem[mem_address[3:0]];

  // Memory model and write-strobe monitor
  always @(posedge clk) begin
    if (mem_writeEnable) begin
      we_total = we_total + 1;
      we_addr  = mem_address;
      we_data  = mem_dataIn;
      mem[mem_address[3:0]] <= mem_dataIn;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        err;
    int          idx, sh, exp_lat, lat, we0;
    logic [31:0] old, nw, v, mask, exp_rdata;
    idx = (a >> 2) & 15;
    sh  = (a & 3) * 8;
    old = ref_mem[idx];
    nw  = old;
    err = (sz == 2'd3) || (sz == 2'd1 && (a & 1) != 0) || (sz == 2'd2 && (a & 3) != 0);
    exp_rdata = 32'h0;
    if (err) begin
      exp_lat = 1;
    end else if (w) begin
      if (sz == 2'd2) begin
        nw = wd;
        exp_lat = 2;
      end else begin
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        nw = (old & ~(mask << sh)) | ((wd & mask) << sh);
        exp_lat = 3;
      end
      ref_mem[idx] = nw;
    end else begin
      exp_lat = 2;
      if (sz == 2'd2) begin
        v = old;
      end else if (sz == 2'd0) begin
        v = (old >> sh) & 32'hFF;
        if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else begin
        v = (old >> sh) & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      exp_rdata = v;
    end

    @(negedge clk);
    check("ready_before", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    we0 = we_total;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("resp_valid", {31'h0, resp_valid}, 32'd1);
    check("resp_error", {31'h0, resp_error}, {31'h0, err});
    check("resp_rdata", resp_rdata, exp_rdata);
    check("we_pulses", we_total - we0, (!err && w) ? 32'd1 : 32'd0);
    if (!err && w) begin
      check("we_addr", {2'b00, we_addr}, a >> 2);
      check("we_data", we_data, nw);
    end
    @(negedge clk);
    check("resp_one_cycle", {31'h0, resp_valid}, 32'd0);
    check("ready_after", {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    int          n, we0;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_we", {31'h0, mem_writeEnable}, 32'd0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_addr", {2'b00, mem_address}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    check("tp_sw_data", we_data, 32'hDEADBEEF);
    check("tp_sw_addr", {2'b00, we_addr}, 32'd4);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    check("tp_lb_13", resp_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    check("tp_lhu_12", resp_rdata, 32'h000080FF);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
    check("tp_lb_10", resp_rdata, 32'h00000001);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
    check("tp_sb_11", we_data, 32'h80FFAA01);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678);
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h55555555);

    // Reset during the WRITE cycle of a halfword store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h0000BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_writeEnable && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_write", {31'h0, mem_writeEnable}, 32'd1);
    we0 = we_total;
    reset = 1'b1;
    #1;
    check("abort_we_drop", {31'h0, mem_writeEnable}, 32'd0);
    check("abort_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", {31'h0, resp_valid}, 32'd0);
      check("abort_ready_after", {31'h0, req_ready}, 32'd1);
    end
    check("abort_no_write", we_total - we0, 32'd0);
    check("abort_mem4", mem[4], 32'h80FFAA01);

    for (int t = 0; t < 200; t++) begin
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(3) != 0) begin
        if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
        if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    for (int i = 0; i < 16; i++) check($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
